des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 184 ++++++++++++++++++
 tb/tb_des_key_schedule.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 load, then one rotated C||D value per round.
// Define KEYSCHED_DECRYPT_EN to enable reverse (decrypt) ordering.
module des_key_schedule #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key64,
  output logic        cd_valid,
  input  logic        cd_ready,
  output logic [55:0] cd56,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  // key64 bit index for each C||D bit (C1 first); key bit n is key64[64-n]
  localparam logic [5:0] PC1_IDX [56] = '{
    6'd7,  6'd15, 6'd23, 6'd31, 6'd39, 6'd47, 6'd55,
    6'd63, 6'd6,  6'd14, 6'd22, 6'd30, 6'd38, 6'd46,
    6'd54, 6'd62, 6'd5,  6'd13, 6'd21, 6'd29, 6'd37,
    6'd45, 6'd53, 6'd61, 6'd4,  6'd12, 6'd20, 6'd28,
    6'd1,  6'd9,  6'd17, 6'd25, 6'd33, 6'd41, 6'd49,
    6'd57, 6'd2,  6'd10, 6'd18, 6'd26, 6'd34, 6'd42,
    6'd50, 6'd58, 6'd3,  6'd11, 6'd19, 6'd27, 6'd35,
    6'd43, 6'd51, 6'd59, 6'd36, 6'd44, 6'd52, 6'd60
  };

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] pc1_w;
  logic [55:0] load_w;
  logic [55:0] rot_w;
  logic        unused_par;

  // Shift-schedule entry (0-based): 1 at 0,1,8,15, else 2
  function automatic logic sh2(input logic [3:0] i);
    return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
  endfunction

  // DES left rotation of both halves: new bit1 = old bit2
  function automatic logic [55:0] rol56(
    input logic [55:0] v,
    input logic        two
  );
    logic [27:0] c, d;
    c = v[27:0];
    d = v[55:28];
    if (two) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {d, c};
  endfunction

  // Parity bits never reach PC-1
  assign unused_par = ^{key64[56], key64[48], key64[40],
                        key64[32], key64[24], key64[16],
                        key64[8],  key64[0]};

  // PC-1 permutation of the incoming key
  always_comb begin
    pc1_w = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_w[i] = key64[PC1_IDX[i]];
    end
  end

`ifdef KEYSCHED_DECRYPT_EN
  logic dec_q, dec_d;

  // DES right rotation of both halves: new bit1 = old bit28
  function automatic logic [55:0] ror56(
    input logic [55:0] v,
    input logic        two
  );
    logic [27:0] c, d;
    c = v[27:0];
    d = v[55:28];
    if (two) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {d, c};
  endfunction

  assign load_w = decrypt ? pc1_w : rol56(pc1_w, 1'b0);
  assign rot_w  = dec_q
                ? ror56(cd_q, sh2(4'd15 - round_q))
                : rol56(cd_q, sh2(round_q + 4'd1));

  // Direction latched at start acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= dec_d;
    end
  end

  // Direction capture next-state
  always_comb begin
    dec_d = dec_q;
    if (state_q == IDLE && start) begin
      dec_d = decrypt;
    end
  end
`else
  logic unused_dec;

  assign unused_dec = decrypt;
  assign load_w     = rol56(pc1_w, 1'b0);
  assign rot_w      = rol56(cd_q, sh2(round_q + 4'd1));
`endif

  // State, value and round registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
    end
  end

  // Next-state: load on start, advance on each transfer
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cd_d    = load_w;
          round_d = '0;
        end
      end
      RUN: begin
        if (cd_ready) begin
          if (round_q == LAST) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            cd_d    = rot_w;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cd_valid = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign cd56     = cd_q;
  assign round    = round_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule with a bit-level reference model.
// Runs a 16-round and a 4-round instance side by side.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        decrypt = 1'b0;
  logic        cd_ready = 1'b1;
  logic [63:0] key64 = '0;

  logic [1:0]  o_valid, o_busy, o_done;
  logic [55:0] o_cd [2];
  logic [3:0]  o_rd [2];

  int nerr = 0;
  int nchk = 0;

`ifdef KEYSCHED_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                            1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [27:0] C0L = 28'b1111000011001100101010101111;
  localparam logic [27:0] D0L = 28'b0101010101100110011110001111;
  localparam logic [27:0] C1L = 28'b1110000110011001010101011111;
  localparam logic [27:0] D1L = 28'b1010101011001100111100011110;

  always #5 clk = ~clk;

  des_key_schedule #(.NUM_ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt),
    .key64(key64), .cd_valid(o_valid[0]), .cd_ready(cd_ready),
    .cd56(o_cd[0]), .round(o_rd[0]), .busy(o_busy[0]),
    .done(o_done[0])
  );

  des_key_schedule #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .decrypt(decrypt),
    .key64(key64), .cd_valid(o_valid[1]), .cd_ready(cd_ready),
    .cd56(o_cd[1]), .round(o_rd[1]), .busy(o_busy[1]),
    .done(o_done[1])
  );

  // C1..C28 literal (C1 is MSB) packed into cd56 layout
  function automatic logic [55:0] pack(input logic [27:0] c,
                                       input logic [27:0] d);
    logic [55:0] r;
    for (int j = 0; j < 28; j++) begin
      r[j]      = c[27-j];
      r[28 + j] = d[27-j];
    end
    return r;
  endfunction

  function automatic logic [55:0] pc1m(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[i] = k[64 - PC1[i]];
    return r;
  endfunction

  // Value for round r: CD0 rotated by cumulative shift total
  function automatic logic [55:0] exp_cd(input logic [55:0] cd0,
                                         input bit dec,
                                         input int r);
    logic [55:0] res;
    int k = 0;
    int e = dec ? 15 - r : r;
    for (int j = 0; j <= e; j++) k += SH[j];
    k = k % 28;
    for (int j = 0; j < 28; j++) begin
      res[j]      = cd0[(j + k) % 28];
      res[28 + j] = cd0[28 + (j + k) % 28];
    end
    return res;
  endfunction

  function automatic int nr(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model state, updated on the DUT clock
  bit          m_run [2];
  bit          m_done [2];
  bit          m_clr [2];
  bit          m_dec [2];
  int          m_round [2];
  logic [55:0] m_cd0 [2];
  int          d_xfer [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i]   <= 1'b0;
        m_done[i]  <= 1'b0;
        m_clr[i]   <= 1'b1;
        m_round[i] <= 0;
      end else if (m_done[i]) begin
        m_done[i] <= 1'b0;
      end else if (m_run[i]) begin
        if (cd_ready) begin
          if (m_round[i] == nr(i) - 1) begin
            m_run[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_round[i] <= m_round[i] + 1;
          end
        end
      end else if ((i == 0) ? start : start4) begin
        m_run[i]   <= 1'b1;
        m_round[i] <= 0;
        m_cd0[i]   <= pc1m(key64);
        m_dec[i]   <= decrypt & DEC_EN;
        m_clr[i]   <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), o_valid[i], m_run[i]);
      chk($sformatf("busy%0d", i), o_busy[i], m_run[i] | m_done[i]);
      chk($sformatf("done%0d", i), o_done[i], m_done[i]);
      if (m_run[i]) begin
        chk($sformatf("round%0d", i), o_rd[i], m_round[i]);
        chk($sformatf("cd%0d", i), o_cd[i],
            exp_cd(m_cd0[i], m_dec[i], m_round[i]));
      end
      if (m_clr[i] && !m_run[i]) begin
        chk($sformatf("rst_cd%0d", i), o_cd[i], 0);
        chk($sformatf("rst_round%0d", i), o_rd[i], 0);
      end
      if (!rst_n) begin
        d_xfer[i] = 0;
      end else begin
        if (o_valid[i] && cd_ready) d_xfer[i]++;
        if (o_done[i]) begin
          chk($sformatf("xfers%0d", i), d_xfer[i], nr(i));
          d_xfer[i] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [63:0] k, input bit dec,
                        input bit both);
    start   = 1'b1;
    start4  = both;
    key64   = k;
    decrypt = dec;
    step();
    start   = 1'b0;
    start4  = 1'b0;
    key64   = {$urandom, $urandom};
    decrypt = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    while (!(o_valid[0] && o_rd[0] == 4'(r)) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      nchk++;
      nerr++;
      $display("FAIL wait_round: got timeout want round %0d", r);
    end
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (o_busy != 2'b00 && n < 400) begin
      if (rnd) begin
        cd_ready = ($urandom_range(0, 9) < 7);
        start    = o_busy[0] && ($urandom_range(0, 7) == 0);
        start4   = o_busy[1] && ($urandom_range(0, 7) == 0);
      end
      key64   = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    start  = 1'b0;
    start4 = 1'b0;
    if (n >= 400) begin
      nchk++;
      nerr++;
      $display("FAIL wait_idle: got timeout want idle");
    end
  endtask

  initial begin
    logic [63:0] k;
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_valid", o_valid[0], 0);
    chk("reset_busy", o_busy[0], 0);
    chk("reset_done", o_done[0], 0);
    chk("reset_cd", o_cd[0], 0);
    rst_n = 1'b1;
    step();

    chk("model_pc1", pc1m(KEY), pack(C0L, D0L));
    chk("model_rnd0", exp_cd(pc1m(KEY), 1'b0, 0), pack(C1L, D1L));

    launch(KEY, 1'b0, 1'b1);
    chk("enc_rnd0_valid", o_valid[0], 1);
    chk("enc_rnd0_cd", o_cd[0], pack(C1L, D1L));
    chk("enc4_rnd0_cd", o_cd[1], pack(C1L, D1L));
    wait_round(15);
    chk("enc_rnd15_cd", o_cd[0], pack(C0L, D0L));
    step();
    chk("done_pulse", o_done[0], 1);
    chk("done_novalid", o_valid[0], 0);
    step();
    chk("done_once", o_done[0], 0);
    wait_idle(1'b0);

    launch(KEY, 1'b1, 1'b1);
    chk("dec_rnd0_cd", o_cd[0],
        DEC_EN ? pack(C0L, D0L) : pack(C1L, D1L));
    wait_idle(1'b0);

    k = {$urandom, $urandom};
    launch(k, 1'b0, 1'b0);
    wait_round(3);
    cd_ready = 1'b0;
    repeat (5) begin
      step();
      chk("bp_round", o_rd[0], 3);
      chk("bp_cd", o_cd[0], exp_cd(pc1m(k), 1'b0, 3));
    end
    cd_ready = 1'b1;
    wait_idle(1'b0);

    launch({$urandom, $urandom}, 1'b0, 1'b1);
    wait_round(7);
    start = 1'b1;
    key64 = ~key64;
    step();
    start = 1'b0;
    wait_idle(1'b0);

    launch({$urandom, $urandom}, 1'b0, 1'b1);
    wait_round(9);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid[0], 0);
    chk("arst_busy", o_busy[0], 0);
    chk("arst_done", o_done[0], 0);
    chk("arst_cd", o_cd[0], 0);
    chk("arst_round", o_rd[0], 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", o_busy[0], 0);
    k = {$urandom, $urandom};
    launch(k, 1'b0, 1'b1);
    chk("post_rst_round", o_rd[0], 0);
    chk("post_rst_valid", o_valid[0], 1);
    chk("post_rst_cd", o_cd[0], exp_cd(pc1m(k), 1'b0, 0));
    wait_idle(1'b0);

    repeat (12) begin
      launch({$urandom, $urandom}, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      wait_idle(1'b1);
      cd_ready = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
